vector_alu: RTL and testbench
=============================

VECTOR_ALU -- requirements
Module: vector_alu

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 64 bits, bit 0 = MSB ([0:63] numbering on all buses).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 rA_64bit_val  input  64  operand A.
REQ-005 rB_64bit_val  input  64  operand B / per-lane shift amount.
REQ-006 R_ins  input  6  function select.
REQ-007 Op_code  input  6  major opcode; 6'b101010 = vector R-type.
REQ-008 WW  input  2  lane width: 00=8, 01=16, 10=32, 11=64 bits.
REQ-009 ALU_out  output  64  registered result.

Function
REQ-010 ALU_out SHALL register the combinational result of the inputs sampled at each rising clk edge; latency is exactly 1 cycle, a new operation is accepted every cycle, and there is no handshake.
REQ-011 Lanes SHALL be numbered from the MSB (lane 0 = bits [0:W-1]); all lane arithmetic is unsigned unless stated, with no carry or borrow between lanes.
REQ-012 Op_code != 101010, or an unlisted R_ins, SHALL produce 0.
REQ-013 R_ins functions:
- 1 VAND, 2 VOR, 3 VXOR: bitwise A op B.
- 4 VNOT: ~A.
- 5 VMOV: A.
- For functions 1-5, WW is ignored.
REQ-014 R_ins functions:
- 6 VADD: per-lane A+B modulo 2^W.
- 7 VSUB: per-lane A-B modulo 2^W.
REQ-015 R_ins functions (widening; WW=11 yields 0):
- 8 VMULEU: even lanes (0,2,..) A*B, 2W-bit product written into the 2W-bit slot covering lanes i and i+1.
- 9 VMULOU: same, using odd lanes.
- 16 VSQEU: even-lane A*A.
- 17 VSQOU: odd-lane A*A.
REQ-016 R_ins functions (shift amount = low log2(W) bits of the same B lane):
- 10 VSLL: logical left shift per lane.
- 11 VSRL: logical right shift per lane.
- 12 VSRA: arithmetic right shift per lane, sign = lane MSB.
REQ-017 R_ins 13 VRTTH: each lane's two halves are swapped (rotate by W/2).
REQ-018 R_ins 14 VDIV: per-lane floor(A/B). R_ins 15 VMOD: per-lane A mod B. For a lane with B=0, VDIV returns all-ones and VMOD returns A.
REQ-019 R_ins 18 VSQRT: per-lane floor(sqrt(A)), zero-extended into the lane.

Reset
REQ-020 While rst=1, ALU_out SHALL be 0 immediately (asynchronously), independent of clk.
REQ-021 A reset asserted mid-stream SHALL discard the pending result; the first result after rst deasserts is produced by the first subsequent rising edge.

Configuration
REQ-022 Macro ALU_DIVSQRT_EN:
- Defined: VDIV, VMOD and VSQRT are implemented per REQ-018/019.
- Undefined: those R_ins values are treated as unlisted and produce 0; no divider or root logic is synthesized.

Structure
REQ-023 A shared package SHALL hold:
- the R-type opcode constant (6'b101010);
- R_ins function codes 1-18 as named constants;
- WW width encodings as named constants.
REQ-024 One sub-module, vector_alu_lane_divsqrt (per-lane unsigned divide/mod/sqrt), SHALL be instantiated only under ALU_DIVSQRT_EN.

Verification
REQ-025 VAND, A=15, B=14 -> ALU_out=14 one cycle later. VNOT, A=0 -> FFFFFFFF_FFFFFFFF.
REQ-026 VADD, A=FFFFFFFF_FFFFFFFF, B=00000000_11111111:
- WW=00 -> FFFFFFFF_10101010;
- WW=11 -> 00000000_11111110.
VSUB, WW=10, B=0F0F0F0F_11111111 -> F0F0F0F0_EEEEEEEE.
REQ-027 VMULEU, WW=01, A=FF000000_FFFFFFFF, B=00020000_000F0001 -> 0001FE00_000EFFF1. VMULEU, WW=10, A=B=20 -> 0 (lane 0 holds 0).
REQ-028 VSQRT, WW=00, A=FF01FFFF_10040001 -> 0F010F0F_04020001. VRTTH, WW=11, A=FFFFFFFF_00000000 -> 00000000_FFFFFFFF.
REQ-029 VSRA, WW=01, A=F0E1F2A2_01010101, B=00030003_00030003 -> FE1CFE54_00200020.
REQ-030 VDIV, WW=00, one B lane = 0 -> that lane = FF. Assert rst mid-stream -> ALU_out=0 before the next clk edge.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// Shared constants for vector_alu: R-type opcode, R_ins function codes and lane-width encodings.
package vector_alu_pkg;

    localparam int DATA_W = 64;

    localparam logic [5:0] OP_VRTYPE = 6'b101010;

    localparam logic [5:0] F_VAND   = 6'd1;
    localparam logic [5:0] F_VOR    = 6'd2;
    localparam logic [5:0] F_VXOR   = 6'd3;
    localparam logic [5:0] F_VNOT   = 6'd4;
    localparam logic [5:0] F_VMOV   = 6'd5;
    localparam logic [5:0] F_VADD   = 6'd6;
    localparam logic [5:0] F_VSUB   = 6'd7;
    localparam logic [5:0] F_VMULEU = 6'd8;
    localparam logic [5:0] F_VMULOU = 6'd9;
    localparam logic [5:0] F_VSLL   = 6'd10;
    localparam logic [5:0] F_VSRL   = 6'd11;
    localparam logic [5:0] F_VSRA   = 6'd12;
    localparam logic [5:0] F_VRTTH  = 6'd13;
    localparam logic [5:0] F_VDIV   = 6'd14;
    localparam logic [5:0] F_VMOD   = 6'd15;
    localparam logic [5:0] F_VSQEU  = 6'd16;
    localparam logic [5:0] F_VSQOU  = 6'd17;
    localparam logic [5:0] F_VSQRT  = 6'd18;

    typedef enum logic [1:0] {
        WW_8  = 2'b00,
        WW_16 = 2'b01,
        WW_32 = 2'b10,
        WW_64 = 2'b11
    } ww_e;

endpackage

// File: rtl/vector_alu_lane_divsqrt.sv
// One W-bit lane of unsigned divide, modulo and floor square root (pure combinational).
// Only instantiated when ALU_DIVSQRT_EN is defined.
module vector_alu_lane_divsqrt #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_quo,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_sqrt
);

    // Divide by zero returns all-ones quotient and passes A through as remainder.
    always_comb begin
        if (i_b == '0) begin
            o_quo = '1;
            o_rem = i_a;
        end else begin
            o_quo = i_a / i_b;
            o_rem = i_a % i_b;
        end
    end

    // Greedy bit-by-bit root: keep each candidate bit whose square still fits under A.
    always_comb begin
        logic [W-1:0] v_root;
        logic [W-1:0] v_trial;
        // NOTE: every variable written here gets a value first so no path leaves it held (no latch).
        v_root  = '0;
        v_trial = '0;
        for (int i = W/2 - 1; i >= 0; i--) begin
            v_trial = v_root | (W'(1) << i);
            if (v_trial * v_trial <= i_a) v_root = v_trial;
        end
        o_sqrt = v_root;
    end

endmodule

// File: rtl/vector_alu.sv
// 64-bit SIMD vector ALU with MSB-first lanes of 8/16/32/64 bits and a one-cycle registered result.
// Define ALU_DIVSQRT_EN to build the per-lane divide, modulo and square-root functions.
module vector_alu
    import vector_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [0:63] rA_64bit_val,
    input  logic [0:63] rB_64bit_val,
    input  logic [5:0]  R_ins,
    input  logic [5:0]  Op_code,
    input  logic [1:0]  WW,
    output logic [0:63] ALU_out
);

    // Descending copies: lane i (from the MSB) sits at [63 - i*W -: W].
    logic [DATA_W-1:0]         w_a;
    logic [DATA_W-1:0]         w_b;
    logic [DATA_W-1:0]         w_result;
    logic [3:0][DATA_W-1:0]    w_lane_res;
    ww_e                       w_ww;
    logic [DATA_W-1:0]         r_alu_out;

    assign w_a  = rA_64bit_val;
    assign w_b  = rB_64bit_val;
    assign w_ww = ww_e'(WW);

    for (genvar g = 0; g < 4; g++) begin : g_ww
        localparam int W  = 8 << g;
        localparam int W2 = 2 * W;
        localparam int N  = DATA_W / W;
        localparam int SW = $clog2(W);

        logic [DATA_W-1:0] w_res;
        logic [DATA_W-1:0] w_wide;

        // Widening ops pack a 2W product per lane pair; no room at W=64, so they yield 0.
        if (W < DATA_W) begin : g_wide
            always_comb begin
                logic [W2-1:0] v_x;
                logic [W2-1:0] v_y;
                int            v_e;
                w_wide = '0;
                v_x    = '0;
                v_y    = '0;
                v_e    = 0;
                for (int k = 0; k < N/2; k++) begin
                    v_e = 2*k + ((R_ins == F_VMULOU || R_ins == F_VSQOU) ? 1 : 0);
                    v_x = W2'(w_a[DATA_W-1 - v_e*W -: W]);
                    v_y = (R_ins == F_VSQEU || R_ins == F_VSQOU) ? v_x
                                                                 : W2'(w_b[DATA_W-1 - v_e*W -: W]);
                    w_wide[DATA_W-1 - k*W2 -: W2] = v_x * v_y;
                end
            end
        end else begin : g_nowide
            assign w_wide = '0;
        end

`ifdef ALU_DIVSQRT_EN
        logic [DATA_W-1:0] w_quo;
        logic [DATA_W-1:0] w_rem;
        logic [DATA_W-1:0] w_sqrt;

        for (genvar l = 0; l < N; l++) begin : g_lane
            vector_alu_lane_divsqrt #(.W(W)) u_divsqrt (
                .i_a    (w_a   [DATA_W-1 - l*W -: W]),
                .i_b    (w_b   [DATA_W-1 - l*W -: W]),
                .o_quo  (w_quo [DATA_W-1 - l*W -: W]),
                .o_rem  (w_rem [DATA_W-1 - l*W -: W]),
                .o_sqrt (w_sqrt[DATA_W-1 - l*W -: W])
            );
        end
`endif

        always_comb begin
            logic [W-1:0]  v_a;
            logic [W-1:0]  v_b;
            logic [SW-1:0] v_sh;
            w_res = '0;
            v_a   = '0;
            v_b   = '0;
            v_sh  = '0;
            for (int i = 0; i < N; i++) begin
                v_a  = w_a[DATA_W-1 - i*W -: W];
                v_b  = w_b[DATA_W-1 - i*W -: W];
                v_sh = v_b[SW-1:0];
                case (R_ins)
                    F_VADD:  w_res[DATA_W-1 - i*W -: W] = v_a + v_b;
                    F_VSUB:  w_res[DATA_W-1 - i*W -: W] = v_a - v_b;
                    F_VSLL:  w_res[DATA_W-1 - i*W -: W] = v_a << v_sh;
                    F_VSRL:  w_res[DATA_W-1 - i*W -: W] = v_a >> v_sh;
                    F_VSRA:  w_res[DATA_W-1 - i*W -: W] = W'($signed(v_a) >>> v_sh);
                    F_VRTTH: w_res[DATA_W-1 - i*W -: W] = {v_a[W/2-1:0], v_a[W-1:W/2]};
                    default: ;
                endcase
            end
            case (R_ins)
                F_VMULEU, F_VMULOU, F_VSQEU, F_VSQOU: w_res = w_wide;
`ifdef ALU_DIVSQRT_EN
                F_VDIV:  w_res = w_quo;
                F_VMOD:  w_res = w_rem;
                F_VSQRT: w_res = w_sqrt;
`endif
                default: ;
            endcase
        end

        assign w_lane_res[g] = w_res;
    end

    // Bitwise functions ignore the lane width; everything else picks the WW-specific result.
    always_comb begin
        w_result = '0;
        if (Op_code == OP_VRTYPE) begin
            case (R_ins)
                F_VAND:  w_result = w_a & w_b;
                F_VOR:   w_result = w_a | w_b;
                F_VXOR:  w_result = w_a ^ w_b;
                F_VNOT:  w_result = ~w_a;
                F_VMOV:  w_result = w_a;
                default: w_result = w_lane_res[w_ww];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) r_alu_out <= '0;
        else     r_alu_out <= w_result;
    end

    assign ALU_out = r_alu_out;

endmodule

// File: tb/tb_vector_alu.sv
// Self-checking bench for vector_alu: directed vector table, reset sequences, and a random
// back-to-back stream checked against a lane-arithmetic reference model.
module tb_vector_alu;

`ifdef ALU_DIVSQRT_EN
    localparam bit DS_EN = 1'b1;
`else
    localparam bit DS_EN = 1'b0;
`endif

    localparam logic [5:0] RT = 6'b101010;

    logic        clk;
    logic        rst;
    logic [0:63] rA_64bit_val;
    logic [0:63] rB_64bit_val;
    logic [5:0]  R_ins;
    logic [5:0]  Op_code;
    logic [1:0]  WW;
    logic [0:63] ALU_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  f;
        logic [5:0]  op;
        logic [1:0]  ww;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    vector_alu dut (
        .clk          (clk),
        .rst          (rst),
        .rA_64bit_val (rA_64bit_val),
        .rB_64bit_val (rB_64bit_val),
        .R_ins        (R_ins),
        .Op_code      (Op_code),
        .WW           (WW),
        .ALU_out      (ALU_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [63:0] a, input logic [63:0] b,
                       input logic [5:0] f, input logic [1:0] ww, input logic [63:0] exp,
                       input logic [5:0] op = RT);
        vecs.push_back('{nm, a, b, f, op, ww, exp});
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [5:0] f,
                         input logic [5:0] op, input logic [1:0] ww);
        rA_64bit_val = a;
        rB_64bit_val = b;
        R_ins        = f;
        Op_code      = op;
        WW           = ww;
    endtask

    // ---------------- reference model: plain per-lane integer arithmetic ----------------
    function automatic logic [63:0] lane_of(input logic [63:0] v, input int i, input int w);
        int n = 64 / w;
        if (w == 64) return v;
        return (v >> ((n - 1 - i) * w)) & ((64'd1 << w) - 1);
    endfunction

    function automatic logic [63:0] isqrt(input logic [63:0] x);
        logic [63:0]  lo = 64'd0;
        logic [63:0]  hi = 64'h1_0000_0000;
        logic [63:0]  mid;
        logic [127:0] sq;
        while (hi - lo > 1) begin
            mid = (lo + hi) >> 1;
            sq  = 128'(mid) * 128'(mid);
            if (sq <= 128'(x)) lo = mid;
            else               hi = mid;
        end
        return lo;
    endfunction

    function automatic logic [63:0] ref_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic [5:0] f, input logic [5:0] op,
                                              input logic [1:0] ww);
        int          w    = 8 << ww;
        int          n    = 64 / w;
        logic [63:0] mask = (w == 64) ? '1 : ((64'd1 << w) - 1);
        logic [63:0] r    = 64'd0;
        logic [63:0] x, y, z;
        int          sh, pos, e;
        if (op != RT) return 64'd0;
        case (f)
            6'd1: return a & b;
            6'd2: return a | b;
            6'd3: return a ^ b;
            6'd4: return ~a;
            6'd5: return a;
            default: ;
        endcase
        if (f == 6'd8 || f == 6'd9 || f == 6'd16 || f == 6'd17) begin
            if (w == 64) return 64'd0;
            for (int k = 0; k < n / 2; k++) begin
                e = 2 * k + ((f == 6'd9 || f == 6'd17) ? 1 : 0);
                x = lane_of(a, e, w);
                y = (f >= 6'd16) ? x : lane_of(b, e, w);
                r |= (x * y) << ((n / 2 - 1 - k) * 2 * w);
            end
            return r;
        end
        for (int i = 0; i < n; i++) begin
            x   = lane_of(a, i, w);
            y   = lane_of(b, i, w);
            sh  = int'(y % w);
            pos = (n - 1 - i) * w;
            case (f)
                6'd6:  z = x + y;
                6'd7:  z = x - y;
                6'd10: z = x << sh;
                6'd11: z = x >> sh;
                6'd12: begin
                    z = x >> sh;
                    if (x[w-1]) z |= mask & ~(mask >> sh);
                end
                6'd13: z = (x >> (w / 2)) | (x << (w / 2));
                6'd14: z = !DS_EN ? 64'd0 : (y == 0) ? mask : x / y;
                6'd15: z = !DS_EN ? 64'd0 : (y == 0) ? x : x % y;
                6'd18: z = !DS_EN ? 64'd0 : isqrt(x);
                default: z = 64'd0;
            endcase
            r |= (z & mask) << pos;
        end
        return r;
    endfunction

    initial begin
        logic [63:0] prev_exp;
        logic [63:0] ra, rb;
        logic [5:0]  rf, rop;
        logic [1:0]  rww;

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(64'd0, 64'd0, 6'd4, RT, 2'b00);
        #1 check("reset_async", ALU_out, 64'd0);
        @(posedge clk); #1 check("reset_hold_edge", ALU_out, 64'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("reset_release", ALU_out, 64'd0);

        // ---------------- directed table ----------------
        add("vand",         64'd15, 64'd14, 6'd1, 2'b00, 64'd14);
        add("vnot",         64'd0, 64'd0, 6'd4, 2'b11, 64'hFFFFFFFF_FFFFFFFF);
        add("vor",          64'hF0F0_0000_1234_0000, 64'h0F00_00FF_0000_5678, 6'd2, 2'b01, 64'hFFF0_00FF_1234_5678);
        add("vxor",         64'hFFFF_0000_AAAA_5555, 64'hFFFF_FFFF_5555_5555, 6'd3, 2'b10, 64'h0000_FFFF_FFFF_0000);
        add("vmov",         64'h0123_4567_89AB_CDEF, 64'd0, 6'd5, 2'b00, 64'h0123_4567_89AB_CDEF);
        add("vadd_w8",      64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 6'd6, 2'b00, 64'hFFFFFFFF_10101010);
        add("vadd_w64",     64'hFFFFFFFF_FFFFFFFF, 64'h00000000_11111111, 6'd6, 2'b11, 64'h00000000_11111110);
        add("vsub_w32",     64'hFFFFFFFF_FFFFFFFF, 64'h0F0F0F0F_11111111, 6'd7, 2'b10, 64'hF0F0F0F0_EEEEEEEE);
        add("vmuleu_w16",   64'hFF000000_FFFFFFFF, 64'h00020000_000F0001, 6'd8, 2'b01, 64'h0001FE00_000EFFF1);
        add("vmuleu_w32",   64'd20, 64'd20, 6'd8, 2'b10, 64'd0);
        add("vmuleu_w64",   64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 6'd8, 2'b11, 64'd0);
        add("vmulou_w32",   64'h00000002_FFFFFFFF, 64'h00000003_FFFFFFFF, 6'd9, 2'b10, 64'hFFFFFFFE_00000001);
        add("vsqou_w8",     64'h00030005_00070009, 64'd0, 6'd17, 2'b00, 64'h00090019_00310051);
        add("vsll_w8",      64'h01010101_01010101, 64'h00010203_04050607, 6'd10, 2'b00, 64'h01020408_10204080);
        add("vsrl_w64",     64'h80000000_00000000, 64'h00000000_0000003F, 6'd11, 2'b11, 64'd1);
        add("vsra_w16",     64'hF0E1F2A2_01010101, 64'h00030003_00030003, 6'd12, 2'b01, 64'hFE1CFE54_00200020);
        add("vrtth_w64",    64'hFFFFFFFF_00000000, 64'd0, 6'd13, 2'b11, 64'h00000000_FFFFFFFF);
        add("vrtth_w8",     64'h12345678_9ABCDEF0, 64'd0, 6'd13, 2'b00, 64'h21436587_A9CBED0F);
        add("vsqrt_w8",     64'hFF01FFFF_10040001, 64'd0, 6'd18, 2'b00, DS_EN ? 64'h0F010F0F_04020001 : 64'd0);
        add("vdiv_w8_b0",   64'h10203040_50607080, 64'h02000405_0A000810, 6'd14, 2'b00, DS_EN ? 64'h08FF0C0C_08FF0E08 : 64'd0);
        add("vmod_w8_b0",   64'h10203040_50607080, 64'h02000405_0A000810, 6'd15, 2'b00, DS_EN ? 64'h00200004_00600000 : 64'd0);
        add("bad_opcode",   64'd15, 64'd14, 6'd1, 2'b00, 64'd0, 6'b000000);
        add("unlisted_0",   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 2'b00, 64'd0);
        add("unlisted_19",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd19, 2'b11, 64'd0);

        foreach (vecs[i]) begin
            @(negedge clk) drive(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].op, vecs[i].ww);
            @(negedge clk) check(vecs[i].name, ALU_out, vecs[i].exp);
        end

        // ---------------- mid-stream reset ----------------
        @(negedge clk) drive(64'hDEADBEEF_CAFEF00D, 64'd0, 6'd5, RT, 2'b00);
        @(posedge clk); #1 check("pre_reset_result", ALU_out, 64'hDEADBEEF_CAFEF00D);
        #1;
        drive(64'd0, 64'd0, 6'd4, RT, 2'b00);
        rst = 1'b1;
        #1 check("midstream_reset_async", ALU_out, 64'd0);
        @(posedge clk); #1 check("midstream_reset_held", ALU_out, 64'd0);
        #1 rst = 1'b0;
        #1 check("pending_discarded", ALU_out, 64'd0);
        @(posedge clk); #1 check("first_after_reset", ALU_out, 64'hFFFFFFFF_FFFFFFFF);

        // ---------------- random back-to-back stream ----------------
        @(negedge clk);
        ra  = {$urandom, $urandom};
        rb  = {$urandom, $urandom};
        rf  = 6'($urandom_range(0, 19));
        rww = 2'($urandom_range(0, 3));
        drive(ra, rb, rf, RT, rww);
        prev_exp = ref_model(ra, rb, rf, RT, rww);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            check($sformatf("rand%0d", i), ALU_out, prev_exp);
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb &= 64'hFF00FF00_00FF00FF;
            rf  = 6'($urandom_range(0, 19));
            rop = ($urandom_range(0, 15) == 0) ? 6'($urandom) : RT;
            rww = 2'($urandom_range(0, 3));
            drive(ra, rb, rf, rop, rww);
            prev_exp = ref_model(ra, rb, rf, rop, rww);
        end
        @(negedge clk) check("rand_last", ALU_out, prev_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
